// File: rtl/lfsr_rand_sched.sv
// Seeds, sequences and shares one external LFSR between NUM_REQ requesters, handing out
// one fresh random word per round-robin grant. States: SEED load | WARM/ADV advance | READY grant.
module lfsr_rand_sched #(
  parameter int                   NUM_BITS     = 8,
  parameter int                   NUM_REQ      = 4,
  parameter int                   STEPS        = 8,
  parameter logic [NUM_BITS-1:0]  DEFAULT_SEED = {{(NUM_BITS-1){1'b0}}, 1'b1}
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Seed_Load,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic [NUM_REQ-1:0]  i_Req,
  output logic [NUM_REQ-1:0]  o_Gnt,
  output logic                o_Rand_Valid,
  output logic [NUM_BITS-1:0] o_Rand_Data,
  output logic                o_Ready,
  output logic                o_Period_Wrap,
  output logic                o_LFSR_Enable,
  output logic                o_LFSR_Seed_DV,
  output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
  input  logic [NUM_BITS-1:0] i_LFSR_Data,
  input  logic                i_LFSR_Done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]        NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]      LAST_REQ  = PTR_W'(NUM_REQ - 1);
  localparam logic [7:0]            STEPS_W   = 8'(STEPS);
  localparam logic [NUM_BITS-1:0]   ALL_ONES  = '1;

  typedef enum logic [1:0] {SEED, WARM, READY, ADV} state_t;

  state_t               state, state_nxt;
  logic [7:0]           count, count_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt, off, pick;
  logic [PTR_W:0]       sum;
  logic [NUM_BITS-1:0]  seed;
  logic                 adv_prev;
  logic                 found;
  logic                 grant_fire;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;

  // Rotate requests so bit 0 is the requester the pointer names; lowest set bit wins.
  assign req_dbl = {i_Req, i_Req};
  assign req_rot = req_dbl[ptr +: NUM_REQ];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = PTR_W'(i);
      end
    end
  end

  assign sum     = {1'b0, ptr} + {1'b0, off};
  assign pick    = (sum >= NUM_REQ_W) ? PTR_W'(sum - NUM_REQ_W) : sum[PTR_W-1:0];
  assign ptr_nxt = (pick == LAST_REQ) ? '0 : pick + PTR_W'(1);

  assign o_LFSR_Seed_Data = seed;

  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    grant_fire     = 1'b0;
    o_LFSR_Enable  = 1'b0;
    o_LFSR_Seed_DV = 1'b0;
    o_Ready        = 1'b0;
    case (state)
      SEED: begin
        o_LFSR_Enable  = 1'b1;
        o_LFSR_Seed_DV = 1'b1;
        state_nxt      = WARM;
        count_nxt      = STEPS_W;
      end
      WARM, ADV: begin
        o_LFSR_Enable = 1'b1;
        count_nxt     = count - 8'd1;
        if (count <= 8'd1) state_nxt = READY;
      end
      READY: begin
        o_Ready = 1'b1;
        if (found) begin
          grant_fire = 1'b1;
          state_nxt  = ADV;
          count_nxt  = STEPS_W;
        end
      end
      default: state_nxt = SEED;
    endcase
    // A reload pre-empts any grant decided in the same cycle.
    if (i_Seed_Load) begin
      state_nxt  = SEED;
      grant_fire = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= SEED;
      count         <= '0;
      ptr           <= '0;
      seed          <= DEFAULT_SEED;
      o_Gnt         <= '0;
      o_Rand_Valid  <= 1'b0;
      o_Rand_Data   <= '0;
      o_Period_Wrap <= 1'b0;
      adv_prev      <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      adv_prev      <= (state == WARM) || (state == ADV);
      o_Period_Wrap <= adv_prev && i_LFSR_Done;
      o_Rand_Valid  <= grant_fire;
      o_Gnt         <= grant_fire ? (NUM_REQ'(1) << pick) : '0;
      if (grant_fire) begin
        o_Rand_Data <= i_LFSR_Data;
        ptr         <= ptr_nxt;
      end
      // All-ones would lock the XNOR LFSR, so it falls back to the default seed.
      if (i_Seed_Load) seed <= (i_Seed_Data == ALL_ONES) ? DEFAULT_SEED : i_Seed_Data;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_sched.sv
// Bench for lfsr_rand_sched: an XNOR LFSR (taps 8,6,5,4) as environment, a timeline-level
// reference model checked every cycle, and directed scenarios with hand-computed values.
module tb_lfsr_rand_sched;

  localparam int         NR  = 4;
  localparam int         ST  = 8;
  localparam logic [7:0] DEF = 8'h01;

  logic       clk = 1'b0;
  logic       rst, seed_load;
  logic [7:0] seed_data;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       rand_valid, ready, period_wrap, lfsr_en, lfsr_dv, lfsr_done;
  logic [7:0] rand_data, lfsr_seed, lfsr_data;

  always #5 clk = ~clk;

  lfsr_rand_sched #(.NUM_BITS(8), .NUM_REQ(NR), .STEPS(ST), .DEFAULT_SEED(DEF)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Seed_Load(seed_load), .i_Seed_Data(seed_data),
    .i_Req(req), .o_Gnt(gnt), .o_Rand_Valid(rand_valid), .o_Rand_Data(rand_data),
    .o_Ready(ready), .o_Period_Wrap(period_wrap), .o_LFSR_Enable(lfsr_en),
    .o_LFSR_Seed_DV(lfsr_dv), .o_LFSR_Seed_Data(lfsr_seed),
    .i_LFSR_Data(lfsr_data), .i_LFSR_Done(lfsr_done));

  // Environment LFSR, 1-indexed like the shared LFSR core; it has no reset.
  logic [8:1] lfsr_q = '0;
  always @(posedge clk) begin
    if (lfsr_en === 1'b1) begin
      if (lfsr_dv === 1'b1) lfsr_q <= lfsr_seed;
      else lfsr_q <= {lfsr_q[7:1], lfsr_q[8] ^~ lfsr_q[6] ^~ lfsr_q[5] ^~ lfsr_q[4]};
    end
  end
  assign lfsr_data = lfsr_q;
  assign lfsr_done = (lfsr_q == lfsr_seed);

  int total = 0;
  int bad   = 0;

  // Reference model: active seed, model LFSR value, busy timeline and round-robin pointer.
  logic [7:0] m_seed = DEF;
  logic [7:0] m_val  = '0;
  bit         m_loading = 1'b0;
  bit         m_stepped = 1'b0;
  int         m_left = 0;
  int         m_ptr  = 0;
  int         cyc    = 0;
  logic [3:0] e_gnt  = '0;
  bit         e_valid = 1'b0;
  bit         e_wrap  = 1'b0;
  logic [7:0] e_data  = '0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
  endfunction

  function automatic logic [7:0] lfsr_after(input logic [7:0] s, input int n);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lfsr_next(v);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic model_update();
    bit         stepping, hit;
    logic [7:0] v_next;
    int         k, j;
    stepping = !m_loading && (m_left > 0);
    if (m_loading) v_next = m_seed;
    else if (stepping) v_next = lfsr_next(m_val);
    else v_next = m_val;
    e_wrap  = m_stepped && (m_val == m_seed);
    e_gnt   = '0;
    e_valid = 1'b0;
    if (rst) begin
      m_seed = DEF; m_ptr = 0; m_loading = 1'b1; m_left = 0;
      e_wrap = 1'b0; stepping = 1'b0; cyc = 1;
    end else begin
      cyc++;
      if (seed_load) begin
        m_seed    = (seed_data == 8'hFF) ? DEF : seed_data;
        m_loading = 1'b1;
        m_left    = 0;
      end else if (m_loading) begin
        m_loading = 1'b0;
        m_left    = ST;
      end else if (m_left > 0) begin
        m_left--;
      end else begin
        hit = 1'b0; k = 0;
        for (int i = 0; i < NR; i++) begin
          j = (m_ptr + i) % NR;
          if (!hit && req[j[1:0]]) begin hit = 1'b1; k = j; end
        end
        if (hit) begin
          e_gnt = 4'(1 << k); e_valid = 1'b1; e_data = m_val;
          m_ptr = (k + 1) % NR; m_left = ST;
        end
      end
    end
    m_val     = v_next;
    m_stepped = stepping;
  endtask

  task automatic compare_all();
    bit exp_ready;
    exp_ready = !m_loading && (m_left == 0);
    chk("gnt", gnt, e_gnt);
    chk("valid", rand_valid, e_valid);
    if (e_valid) chk("data", rand_data, e_data);
    chk("ready", ready, exp_ready);
    chk("enable", lfsr_en, !exp_ready);
    chk("seed_dv", lfsr_dv, m_loading);
    chk("seed_data", lfsr_seed, m_seed);
    chk("wrap", period_wrap, e_wrap);
  endtask

  task automatic cyc_step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    do begin cyc_step(); n++; end while (rand_valid !== 1'b1 && n < lim);
    if (rand_valid !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_valid: no grant within %0d cycles", lim);
    end
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    do begin cyc_step(); n++; end while (ready !== 1'b1 && n < lim);
    if (ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_ready: not ready within %0d cycles", lim);
    end
  endtask

  initial begin
    int n;
    int wraps[$];
    rst = 1'b1; seed_load = 1'b0; seed_data = '0; req = '0;

    chk("pin_8_steps", lfsr_after(DEF, 8), 8'hE8);
    chk("pin_16_steps", lfsr_after(DEF, 16), 8'h72);
    chk("pin_period", lfsr_after(DEF, 255), DEF);

    // 1: reset release, no requests
    repeat (3) cyc_step();
    chk("t1_reset_gnt", gnt, 4'b0);
    chk("t1_reset_data", rand_data, 8'h00);
    rst = 1'b0;
    chk("t1_seed_dv", lfsr_dv, 1'b1);
    repeat (8) cyc_step();
    chk("t1_cyc9_ready", ready, 1'b0);
    chk("t1_cyc9_enable", lfsr_en, 1'b1);
    cyc_step();
    chk("t1_cyc10_ready", ready, 1'b1);
    chk("t1_cyc10_enable", lfsr_en, 1'b0);
    repeat (2) cyc_step();

    // 2: all requesting, round-robin every 9 cycles
    req = 4'b1111;
    cyc_step();
    chk("t2_g0", gnt, 4'b0001);
    chk("t2_d0", rand_data, 8'hE8);
    repeat (9) cyc_step();
    chk("t2_g1", gnt, 4'b0010);
    chk("t2_d1", rand_data, 8'h72);
    repeat (9) cyc_step();
    chk("t2_g2", gnt, 4'b0100);
    repeat (9) cyc_step();
    chk("t2_g3", gnt, 4'b1000);
    repeat (9) cyc_step();
    chk("t2_g4", gnt, 4'b0001);

    // 3: illegal seed falls back to default; legal seed is taken as-is
    seed_load = 1'b1; seed_data = 8'hFF;
    cyc_step();
    seed_load = 1'b0;
    chk("t3_ff_seed", lfsr_seed, 8'h01);
    wait_valid(20, n);
    chk("t3_restart_data", rand_data, 8'hE8);
    chk("t3_ptr_kept", gnt, 4'b0010);
    seed_load = 1'b1; seed_data = 8'h5A; req = 4'b0000;
    cyc_step();
    seed_load = 1'b0;
    chk("t3_5a_seed", lfsr_seed, 8'h5A);

    // 4: reload during ADV with pointer at 2
    wait_ready(20);
    req = 4'b0010;
    wait_valid(5, n);
    chk("t4_setup_gnt", gnt, 4'b0010);
    req = 4'b0100;
    repeat (2) cyc_step();
    seed_load = 1'b1; seed_data = 8'hC3;
    cyc_step();
    seed_load = 1'b0;
    wait_valid(20, n);
    chk("t4_latency", n, 10);
    chk("t4_gnt", gnt, 4'b0100);
    req = 4'b1111;
    wait_valid(20, n);
    chk("t4_next_gnt", gnt, 4'b1000);

    // 5: reset mid-ADV with a non-zero pointer
    wait_valid(20, n);
    chk("t5_setup_gnt", gnt, 4'b0001);
    repeat (2) cyc_step();
    rst = 1'b1;
    cyc_step();
    rst = 1'b0;
    chk("t5_gnt", gnt, 4'b0000);
    chk("t5_valid", rand_valid, 1'b0);
    chk("t5_data", rand_data, 8'h00);
    chk("t5_seed_state", lfsr_dv, 1'b1);
    wait_valid(20, n);
    chk("t5_first_gnt", gnt, 4'b0001);
    chk("t5_first_cyc", cyc, 11);
    chk("t5_first_data", rand_data, 8'hE8);

    // 6: period wrap with one requester held
    rst = 1'b1; req = 4'b0001;
    repeat (2) cyc_step();
    rst = 1'b0;
    while (cyc < 600) begin
      cyc_step();
      if (period_wrap === 1'b1) wraps.push_back(cyc);
    end
    chk("t6_wrap_count", wraps.size(), 2);
    if (wraps.size() >= 2) begin
      chk("t6_wrap0_cyc", wraps[0], 289);
      chk("t6_wrap1_cyc", wraps[1], 576);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
